// File: rtl/min_width_shaper.sv
// min_width_shaper: per-channel minimum-high / minimum-low pulse conditioner
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   en_i       per-channel enable, low forces the channel idle
//   in_i       raw level inputs, synchronous to clk_i
//   clr_ovr_i  clears every sticky overrun flag
//   out_o      shaped outputs, registered
//   busy_o     channel is not idle, registered
//   ovr_o      sticky flags for triggers lost to refractory or one-shot masking
module min_width_shaper #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 23,
  parameter int HIGH_MIN = 60_000,
  parameter int LOW_MIN  = 0,
  parameter int MODE     = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] en_i,
  input  logic [N_CH-1:0] in_i,
  input  logic            clr_ovr_i,
  output logic [N_CH-1:0] out_o,
  output logic [N_CH-1:0] busy_o,
  output logic [N_CH-1:0] ovr_o
);
  typedef enum logic [1:0] {S_LOW, S_HOLD, S_HIGH, S_REST} state_t;
  localparam logic             ONE_SHOT = (MODE != 0);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HI       = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] LO       = CNT_W'(LOW_MIN);
  // without a refractory the falling edge goes straight back to idle
  localparam state_t           FALL_S   = (LOW_MIN == 0) ? S_LOW : S_REST;
  localparam logic [CNT_W-1:0] FALL_Q   = (LOW_MIN == 0) ? '0 : ONE;
  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] q_q     [N_CH];
  logic [CNT_W-1:0] q_d     [N_CH];
  logic [N_CH-1:0]  in_d_q, out_q, out_d, busy_q, busy_d, ovr_q, ovr_d, set, rise, trig;
  assign rise   = in_i & ~in_d_q;
  assign trig   = ONE_SHOT ? rise : in_i;
  assign ovr_d  = set | (ovr_q & ~{N_CH{clr_ovr_i}});
  assign out_o  = out_q;
  assign busy_o = busy_q;
  assign ovr_o  = ovr_q;
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      q_d[c]     = q_q[c];
      out_d[c]   = out_q[c];
      set[c]     = 1'b0;
      case (state_q[c])
        S_LOW: if (trig[c]) begin
          state_d[c] = S_HOLD;
          q_d[c]     = ONE;
          out_d[c]   = 1'b1;
        end
        S_HOLD: begin
          // one-shot ignores any edge until the pulse has finished
          set[c] = ONE_SHOT & rise[c];
          if (q_q[c] != HI) q_d[c] = q_q[c] + ONE;
          else if (ONE_SHOT | ~in_i[c]) begin
            state_d[c] = FALL_S;
            q_d[c]     = FALL_Q;
            out_d[c]   = 1'b0;
          end else state_d[c] = S_HIGH;
        end
        S_HIGH: if (!in_i[c]) begin
          state_d[c] = FALL_S;
          q_d[c]     = FALL_Q;
          out_d[c]   = 1'b0;
        end
        S_REST: begin
          if (q_q[c] != LO) begin
            q_d[c] = q_q[c] + ONE;
            set[c] = rise[c];
          end else if (trig[c]) begin
            // last refractory edge behaves like idle and may retrigger
            state_d[c] = S_HOLD;
            q_d[c]     = ONE;
            out_d[c]   = 1'b1;
          end else begin
            state_d[c] = S_LOW;
            q_d[c]     = '0;
          end
        end
        default: state_d[c] = S_LOW;
      endcase
      if (!en_i[c]) begin
        state_d[c] = S_LOW;
        q_d[c]     = '0;
        out_d[c]   = 1'b0;
        set[c]     = 1'b0;
      end
      busy_d[c] = (state_d[c] != S_LOW);
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= S_LOW;
        q_q[c]     <= '0;
      end
      in_d_q <= '0;
      out_q  <= '0;
      busy_q <= '0;
      ovr_q  <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= state_d[c];
        q_q[c]     <= q_d[c];
      end
      in_d_q <= in_i;
      out_q  <= out_d;
      busy_q <= busy_d;
      ovr_q  <= ovr_d;
    end
  end
endmodule

// File: tb/tb_min_width_shaper.sv
// tb_min_width_shaper: directed + random scoreboard bench over three shaper configurations
module tb_min_width_shaper;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [1:0] en = 2'b11, din = 2'b00;
  logic [1:0] o0, b0, v0, o1, b1, v1, o2, b2, v2;
  int total = 0, bad = 0, hi0 = 0, hi1 = 0, hi2 = 0;
  logic [17:0] sb[$];
  logic mo[3][2], mi[3][2], mv[3][2];
  int   mh[3][2], mr[3][2];
  always #5 clk = ~clk;
  min_width_shaper #(.N_CH(2), .CNT_W(8), .HIGH_MIN(5), .LOW_MIN(3), .MODE(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in_i(din), .clr_ovr_i(clr),
    .out_o(o0), .busy_o(b0), .ovr_o(v0));
  min_width_shaper #(.N_CH(2), .CNT_W(8), .HIGH_MIN(5), .LOW_MIN(3), .MODE(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in_i(din), .clr_ovr_i(clr),
    .out_o(o1), .busy_o(b1), .ovr_o(v1));
  min_width_shaper #(.N_CH(2), .CNT_W(8), .HIGH_MIN(1), .LOW_MIN(0), .MODE(1)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in_i(din), .clr_ovr_i(clr),
    .out_o(o2), .busy_o(b2), .ovr_o(v2));
  task automatic model_push();
    logic [17:0] e;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 2; c++) begin
        logic md, rs, tg, st;
        int hm, lm;
        md = (k != 0);
        hm = (k == 2) ? 1 : 5;
        lm = (k == 2) ? 0 : 3;
        rs = din[c] & ~mi[k][c];
        tg = md ? rs : din[c];
        st = 1'b0;
        if (!rst_n) begin
          mo[k][c] = 1'b0; mh[k][c] = 0; mr[k][c] = 0; mv[k][c] = 1'b0;
        end else begin
          if (!en[c]) begin
            mo[k][c] = 1'b0; mh[k][c] = 0; mr[k][c] = 0;
          end else if (mo[k][c]) begin
            st = md & rs;
            if (mh[k][c] < hm) mh[k][c]++;
            else if (md || !din[c]) begin
              mo[k][c] = 1'b0; mh[k][c] = 0; mr[k][c] = (lm > 0) ? 1 : 0;
            end
          end else if (mr[k][c] > 0 && mr[k][c] < lm) begin
            mr[k][c]++; st = rs;
          end else begin
            mr[k][c] = 0;
            if (tg) begin mo[k][c] = 1'b1; mh[k][c] = 1; end
          end
          mv[k][c] = st | (mv[k][c] & ~clr);
        end
        mi[k][c] = rst_n ? din[c] : 1'b0;
        e[k*6+4+c] = mo[k][c];
        e[k*6+2+c] = mo[k][c] | (mr[k][c] > 0);
        e[k*6+c]   = mv[k][c];
      end
    end
    sb.push_back(e);
  endtask
  task automatic tick(input logic [1:0] e, input logic [1:0] i, input logic r, input logic c);
    logic [17:0] exp_v, act;
    en = e; din = i; rst_n = r; clr = c;
    model_push();
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    act = {o2, b2, v2, o1, b1, v1, o0, b0, v0};
    for (int k = 0; k < 3; k++) begin
      total++;
      assert (act[k*6+:6] === exp_v[k*6+:6]) else begin
        bad++;
        $error("FAIL u%0d out/busy/ovr got=%b exp=%b t=%0t", k, act[k*6+:6], exp_v[k*6+:6], $time);
      end
    end
    if (o0[0]) hi0++;
    if (o1[0]) hi1++;
    if (o0[1]) hi2++;
  endtask
  task automatic run(input int n, input logic [1:0] e, input logic [1:0] i, input logic r, input logic c);
    repeat (n) tick(e, i, r, c);
  endtask
  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++) begin
        mo[k][c] = 1'b0; mi[k][c] = 1'b0; mv[k][c] = 1'b0; mh[k][c] = 0; mr[k][c] = 0;
      end
    #1;
    run(2, 2'b11, 2'b00, 1'b0, 1'b0);
    chk("reset_state", int'({o0, b0, v0, o1, b1, v1}), 0);
    run(2, 2'b11, 2'b00, 1'b1, 1'b0);
    hi0 = 0; hi1 = 0;
    run(2, 2'b11, 2'b01, 1'b1, 1'b0);
    run(10, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("short_pulse_width", hi0, 5);
    chk("short_pulse_oneshot_width", hi1, 5);
    hi0 = 0;
    run(20, 2'b11, 2'b01, 1'b1, 1'b0);
    run(10, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("long_pulse_width", hi0, 20);
    run(8, 2'b11, 2'b01, 1'b1, 1'b0);
    run(1, 2'b11, 2'b00, 1'b1, 1'b0);
    run(6, 2'b11, 2'b01, 1'b1, 1'b0);
    run(10, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("refractory_ovr", int'(v0[0]), 1);
    run(1, 2'b11, 2'b00, 1'b1, 1'b1);
    chk("clr_ovr", int'(v0[0]), 0);
    run(8, 2'b11, 2'b01, 1'b1, 1'b0);
    run(1, 2'b11, 2'b00, 1'b1, 1'b0);
    run(1, 2'b11, 2'b01, 1'b1, 1'b1);
    chk("set_beats_clr", int'(v0[0]), 1);
    run(5, 2'b11, 2'b01, 1'b1, 1'b0);
    run(10, 2'b11, 2'b00, 1'b1, 1'b1);
    run(1, 2'b11, 2'b00, 1'b1, 1'b0);
    hi1 = 0;
    run(20, 2'b11, 2'b01, 1'b1, 1'b0);
    chk("oneshot_single_pulse", hi1, 5);
    chk("oneshot_no_ovr", int'(v1[0]), 0);
    run(2, 2'b11, 2'b00, 1'b1, 1'b0);
    run(2, 2'b11, 2'b01, 1'b1, 1'b0);
    run(1, 2'b11, 2'b00, 1'b1, 1'b0);
    run(3, 2'b11, 2'b01, 1'b1, 1'b0);
    chk("oneshot_hold_ovr", int'(v1[0]), 1);
    run(10, 2'b11, 2'b00, 1'b1, 1'b0);
    run(3, 2'b11, 2'b01, 1'b1, 1'b0);
    run(1, 2'b11, 2'b01, 1'b0, 1'b0);
    chk("reset_mid_hold", int'({o0, b0, v0, o1, b1, v1}), 0);
    run(1, 2'b11, 2'b01, 1'b1, 1'b0);
    chk("rise_after_reset", int'(o0[0]), 1);
    run(10, 2'b11, 2'b00, 1'b1, 1'b0);
    run(6, 2'b11, 2'b10, 1'b1, 1'b0);
    run(1, 2'b11, 2'b00, 1'b1, 1'b0);
    run(10, 2'b11, 2'b10, 1'b1, 1'b0);
    run(1, 2'b01, 2'b10, 1'b1, 1'b0);
    chk("disable_out", int'({o0[1], b0[1]}), 0);
    chk("disable_keeps_ovr", int'(v0[1]), 1);
    run(2, 2'b01, 2'b10, 1'b1, 1'b0);
    hi2 = 0;
    run(2, 2'b11, 2'b10, 1'b1, 1'b0);
    run(10, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("reenable_width", hi2, 5);
    for (int n = 0; n < 300; n++)
      tick(($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11, 2'($urandom),
           $urandom_range(0, 49) != 0, $urandom_range(0, 14) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
